// File: rtl/swap_pkg.sv
// Shared types for the register swap engine: FSM state encoding and operation modes.
package swap_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    FIN  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SWAP  = 2'b00,
    COPY  = 2'b01,
    CLEAR = 2'b10,
    RSVD  = 2'b11
  } mode_e;

endpackage

// File: rtl/swap_regfile.sv
// Register bank: one synchronous write port, a combinational bus-read port and a combinational read port.
module swap_regfile #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned NREGS = 8,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             ck_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    bus_raddr_i,
  output logic [WIDTH-1:0] bus_rdata_o,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge ck_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign bus_rdata_o = regs_q[bus_raddr_i];
  assign rd_data_o   = regs_q[rd_addr_i];

endmodule

// File: rtl/swap_engine.sv
// Register swap/copy/clear engine: a sequencer moving values between bank registers over one shared bus.
module swap_engine
  import swap_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rt,
  input  logic             ld,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] barramento,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  mode_e            mode_q;
  mode_e            req_mode;
  logic [AW-1:0]    ra_q, rb_q, rt_q;
  logic             busy_q, done_q, err_q;
  logic             reject;

  logic             xfer;
  logic             src_zero;
  logic [AW-1:0]    src_idx, dst_idx;
  logic [WIDTH-1:0] bus_rdata;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  assign req_mode = mode_e'(mode);
  assign reject   = (req_mode == RSVD) || ((req_mode == SWAP) && ((rt == ra) || (rt == rb)));

  // busy drops on entry to FIN so it is never high alongside done.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= SWAP;
      ra_q    <= '0;
      rb_q    <= '0;
      rt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w && !ld) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              mode_q  <= req_mode;
              ra_q    <= ra;
              rb_q    <= rb;
              rt_q    <= rt;
              busy_q  <= 1'b1;
              state_q <= (req_mode == SWAP) ? T1 : T3;
            end
          end
        end
        T1: state_q <= T2;
        T2: state_q <= T3;
        T3: begin
          state_q <= FIN;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    xfer     = 1'b0;
    src_zero = 1'b0;
    src_idx  = '0;
    dst_idx  = '0;
    case (state_q)
      T1: begin
        xfer    = 1'b1;
        src_idx = ra_q;
        dst_idx = rt_q;
      end
      T2: begin
        xfer    = 1'b1;
        src_idx = rb_q;
        dst_idx = ra_q;
      end
      T3: begin
        xfer = 1'b1;
        case (mode_q)
          COPY: begin
            src_idx = ra_q;
            dst_idx = rb_q;
          end
          CLEAR: begin
            src_zero = 1'b1;
            dst_idx  = ra_q;
          end
          default: begin
            src_idx = rt_q;
            dst_idx = rb_q;
          end
        endcase
      end
      default: ;
    endcase
  end

  // Bus transfers and direct loads share the single write port; loads only win in IDLE.
  assign barramento = (xfer && !src_zero) ? bus_rdata : '0;
  assign wr_en      = xfer || ((state_q == IDLE) && ld);
  assign wr_addr    = xfer ? dst_idx : ld_addr;
  assign wr_data    = xfer ? barramento : ld_data;

  swap_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .ck_i        (ck),
    .rst_i       (rst),
    .we_i        (wr_en),
    .waddr_i     (wr_addr),
    .wdata_i     (wr_data),
    .bus_raddr_i (src_idx),
    .bus_rdata_o (bus_rdata),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data)
  );

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_swap_engine.sv
// Self-checking bench for swap_engine: directed scenarios plus randomized operations against a register-array model.
`timescale 1ns/1ps
module tb_swap_engine;

  localparam int unsigned WIDTH = 6;
  localparam int unsigned NREGS = 8;
  localparam int unsigned AW    = 3;

  logic             ck = 1'b0;
  logic             rst = 1'b1;
  logic             w = 1'b0;
  logic [1:0]       mode = '0;
  logic [AW-1:0]    ra = '0, rb = '0, rt = '0;
  logic             ld = 1'b0;
  logic [AW-1:0]    ld_addr = '0;
  logic [WIDTH-1:0] ld_data = '0;
  logic [AW-1:0]    rd_addr = '0;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] barramento;
  logic             busy, done, err;

  int checks = 0;
  int errors = 0;
  int mdl [NREGS];

  always #10 ck = ~ck;

  swap_engine #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) dut (
    .ck         (ck),
    .rst        (rst),
    .w          (w),
    .mode       (mode),
    .ra         (ra),
    .rb         (rb),
    .rt         (rt),
    .ld         (ld),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .barramento (barramento),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      rd_addr = AW'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), 32'(rd_data), 32'(mdl[i]));
    end
  endtask

  task automatic load(input int a, input int d);
    ld      = 1'b1;
    ld_addr = AW'(a);
    ld_data = WIDTH'(d);
    tick();
    ld = 1'b0;
    mdl[a] = d;
    check("load_busy", 32'(busy), 0);
  endtask

  task automatic run_op(input string tag, input int m, input int a, input int b, input int t,
                        input bit hold_w, input bit ld_noise);
    int exp_bus[$];
    int tmp;
    bit rej;
    rej = (m == 3) || (m == 0 && (t == a || t == b));
    if (!rej) begin
      case (m)
        0: begin
          exp_bus = '{mdl[a], mdl[b], mdl[a]};
          tmp = mdl[a];
          mdl[t] = tmp;
          mdl[a] = mdl[b];
          mdl[b] = tmp;
        end
        1: begin
          exp_bus = '{mdl[a]};
          mdl[b] = mdl[a];
        end
        default: begin
          exp_bus = '{0};
          mdl[a] = 0;
        end
      endcase
    end
    w = 1'b1; mode = 2'(m); ra = AW'(a); rb = AW'(b); rt = AW'(t);
    tick();
    if (!hold_w) w = 1'b0;
    if (rej) begin
      check({tag, "_err"}, 32'(err), 1);
      check({tag, "_err_done"}, 32'(done), 0);
      check({tag, "_err_busy"}, 32'(busy), 0);
      check({tag, "_err_bus"}, 32'(barramento), 0);
      w = 1'b0;
      tick();
      check({tag, "_err_pulse"}, 32'(err), 0);
      check({tag, "_err_idle"}, 32'(busy), 0);
    end else begin
      foreach (exp_bus[k]) begin
        check($sformatf("%s_bus%0d", tag, k), 32'(barramento), 32'(exp_bus[k]));
        check($sformatf("%s_busy%0d", tag, k), 32'(busy), 1);
        check($sformatf("%s_early_done%0d", tag, k), 32'(done), 0);
        if (ld_noise) begin
          ld = 1'b1;
          ld_addr = AW'($urandom_range(NREGS - 1));
          ld_data = WIDTH'($urandom);
        end
        tick();
        ld = 1'b0;
      end
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_done_busy"}, 32'(busy), 0);
      check({tag, "_done_err"}, 32'(err), 0);
      check({tag, "_done_bus"}, 32'(barramento), 0);
      tick();
      w = 1'b0;
      check({tag, "_done_pulse"}, 32'(done), 0);
      check({tag, "_idle"}, 32'(busy), 0);
      tick();
      check({tag, "_no_second"}, 32'(busy), 0);
      check({tag, "_no_second_done"}, 32'(done), 0);
    end
    check_regs(tag);
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = 0;

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_bus", 32'(barramento), 0);
    check_regs("rst");
    rst = 1'b0;
    tick();

    // Basic swap
    load(3, 5);
    load(4, 9);
    run_op("swap", 0, 3, 4, 2, 1'b0, 1'b0);

    // Copy then clear
    load(1, 63);
    run_op("copy", 1, 1, 6, 0, 1'b0, 1'b0);
    run_op("clear", 2, 1, 0, 0, 1'b0, 1'b0);

    // Rejections
    run_op("rsvd", 3, 2, 5, 7, 1'b0, 1'b0);
    run_op("rt_eq_ra", 0, 3, 4, 3, 1'b0, 1'b0);
    run_op("rt_eq_rb", 0, 3, 4, 4, 1'b0, 1'b0);

    // Swap with ra==rb
    load(5, 17);
    run_op("same", 0, 5, 5, 0, 1'b0, 1'b0);

    // w held through the whole swap, plus a load of r5 while busy
    w = 1'b1; mode = 2'b00; ra = 3'd3; rb = 3'd4; rt = 3'd2;
    run_op("hold", 0, 3, 4, 2, 1'b1, 1'b0);
    w = 1'b1; mode = 2'b00; ra = 3'd0; rb = 3'd1; rt = 3'd6;
    tick();
    w = 1'b0;
    ld = 1'b1; ld_addr = 3'd5; ld_data = 6'd7;
    tick();
    ld = 1'b0;
    repeat (3) tick();
    tmp_swap(0, 1, 6);
    check_regs("ld_busy");

    // ld and w in the same IDLE cycle
    ld = 1'b1; ld_addr = 3'd0; ld_data = 6'd42;
    w = 1'b1; mode = 2'b00; ra = 3'd1; rb = 3'd2; rt = 3'd3;
    tick();
    ld = 1'b0; w = 1'b0;
    mdl[0] = 42;
    check("ldw_busy", 32'(busy), 0);
    check("ldw_err", 32'(err), 0);
    tick();
    check("ldw_busy2", 32'(busy), 0);
    check("ldw_done", 32'(done), 0);
    check_regs("ldw");

    // Reset during T2 of a swap
    load(3, 5);
    load(4, 9);
    w = 1'b1; mode = 2'b00; ra = 3'd3; rb = 3'd4; rt = 3'd2;
    tick();
    w = 1'b0;
    check("mid_t1_bus", 32'(barramento), 5);
    tick();
    check("mid_t2_bus", 32'(barramento), 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    foreach (mdl[i]) mdl[i] = 0;
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(done), 0);
    check("mid_bus", 32'(barramento), 0);
    check_regs("mid");
    tick();
    check("mid_done2", 32'(done), 0);
    load(3, 5);
    load(4, 9);
    run_op("after_rst", 0, 3, 4, 2, 1'b0, 1'b0);

    // Randomized operations with occasional loads and load noise while busy
    for (int n = 0; n < 40; n++) begin
      int a, b, t, m;
      if ($urandom_range(1) == 1) load(int'($urandom_range(NREGS - 1)), int'($urandom_range(63)));
      m = int'($urandom_range(3));
      a = int'($urandom_range(NREGS - 1));
      b = int'($urandom_range(NREGS - 1));
      t = int'($urandom_range(NREGS - 1));
      run_op($sformatf("rnd%0d", n), m, a, b, t, bit'($urandom_range(1)), bit'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Model update for the untimed swap in the ld-while-busy scenario.
  task automatic tmp_swap(input int a, input int b, input int t);
    int v;
    v = mdl[a];
    mdl[t] = v;
    mdl[a] = mdl[b];
    mdl[b] = v;
  endtask

endmodule
